// File: rtl/friscv_dmem_responder_if.sv
// Purpose: AXI4 single-beat load/store bus between the LSU (master) and the data memory (slave).
// Ports:   AW (awvalid/awready/awaddr/awid/awprot/awcache), W (wvalid/wready/wdata/wstrb),
//          B (bvalid/bready/bid/bresp), AR (arvalid/arready/araddr/arid/arprot/arcache), R (rvalid/rready/rid/rresp/rdata).
interface friscv_dmem_responder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [AXI_ADDR_W-1:0]     awaddr;
  logic [AXI_ID_W-1:0]       awid;
  logic [2:0]                awprot;
  logic [3:0]                awcache;
  logic                      wvalid;
  logic                      wready;
  logic [AXI_DATA_W-1:0]     wdata;
  logic [AXI_DATA_W/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ID_W-1:0]       bid;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_ADDR_W-1:0]     araddr;
  logic [AXI_ID_W-1:0]       arid;
  logic [2:0]                arprot;
  logic [3:0]                arcache;
  logic                      rvalid;
  logic                      rready;
  logic [AXI_ID_W-1:0]       rid;
  logic [1:0]                rresp;
  logic [AXI_DATA_W-1:0]     rdata;

  modport slave (
    input  awvalid, awaddr, awid, awprot, awcache,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arid, arprot, arcache,
    output arready,
    output rvalid, rid, rresp, rdata,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awprot, awcache,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arid, arprot, arcache,
    input  arready,
    input  rvalid, rid, rresp, rdata,
    output rready
  );
endinterface

// File: rtl/friscv_dmem_responder.sv
// Purpose: AXI4 single-beat data memory: strobed writes and word reads on an internal RAM,
//          in-order B and R responses with echoed IDs, up to OSTD_NUM outstanding per channel.
// Ports:   aclk, aresetn (async, active low), srst (sync, active high), bus (slave modport).
//          Latency: B two cycles after AW+W accept, R three cycles after AR accept.
//          Backpressure: readies drop when the request FIFOs are full; B/R hold until taken.

// Small synchronous FIFO; the head reads as zero while empty so idle payloads are clean.
module friscv_dmem_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     srst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

module friscv_dmem_responder #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int OSTD_NUM   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  friscv_dmem_responder_if.slave  bus
);
  localparam int NB  = AXI_DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int MA  = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(OSTD_NUM) + 1;

  // Everything that could accept or emit is held off while either reset is active.
  logic run;
  assign run = aresetn & ~srst;

  // ---------------- request FIFOs ----------------
  logic                  aw_empty, aw_full, w_empty, w_full, ar_empty, ar_full;
  logic [CW-1:0]         aw_count, w_count, ar_count;
  logic [AXI_ADDR_W-1:0] aw_h_addr, ar_h_addr;
  logic [AXI_ID_W-1:0]   aw_h_id, ar_h_id;
  logic [AXI_DATA_W-1:0] w_h_dat;
  logic [NB-1:0]         w_h_strb;
  logic                  commit, issue;

  assign bus.awready = run & ~aw_full;
  assign bus.wready  = run & ~w_full;
  assign bus.arready = run & ~ar_full;

  friscv_dmem_fifo #(.W(AXI_ADDR_W + AXI_ID_W), .DEPTH(OSTD_NUM)) u_aw_fifo (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .push(bus.awvalid & bus.awready), .push_dat({bus.awaddr, bus.awid}),
    .pop(commit), .head_dat({aw_h_addr, aw_h_id}),
    .empty(aw_empty), .full(aw_full), .count(aw_count)
  );

  friscv_dmem_fifo #(.W(AXI_DATA_W + NB), .DEPTH(OSTD_NUM)) u_w_fifo (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .push(bus.wvalid & bus.wready), .push_dat({bus.wdata, bus.wstrb}),
    .pop(commit), .head_dat({w_h_dat, w_h_strb}),
    .empty(w_empty), .full(w_full), .count(w_count)
  );

  friscv_dmem_fifo #(.W(AXI_ADDR_W + AXI_ID_W), .DEPTH(OSTD_NUM)) u_ar_fifo (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .push(bus.arvalid & bus.arready), .push_dat({bus.araddr, bus.arid}),
    .pop(issue), .head_dat({ar_h_addr, ar_h_id}),
    .empty(ar_empty), .full(ar_full), .count(ar_count)
  );

  // ---------------- address decode ----------------
  logic [AXI_ADDR_W-1:0] aw_idx, ar_idx;
  logic                  aw_ok, ar_ok;

  assign aw_idx = aw_h_addr >> OFF;
  assign ar_idx = ar_h_addr >> OFF;
  assign aw_ok  = (aw_idx < AXI_ADDR_W'(MEM_DEPTH));
  assign ar_ok  = (ar_idx < AXI_ADDR_W'(MEM_DEPTH));

  // ---------------- response FIFOs ----------------
  logic                  b_empty, b_full, r_empty, r_full;
  logic [CW-1:0]         b_count, r_count;
  logic                  rd_pend;
  logic [AXI_ID_W-1:0]   rd_id_q;
  logic                  rd_ok_q;
  logic [AXI_DATA_W-1:0] ram_q;
  logic [CW:0]           r_credit;

  assign commit = run & ~aw_empty & ~w_empty & ~b_full;

  // A read occupies an R slot from issue onward, so the one in the RAM pipe counts as used.
  assign r_credit = {1'b0, r_count} + {{CW{1'b0}}, rd_pend};
  assign issue    = run & ~ar_empty & (r_credit < (CW+1)'(OSTD_NUM));

  friscv_dmem_fifo #(.W(AXI_ID_W + 2), .DEPTH(OSTD_NUM)) u_b_fifo (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .push(commit), .push_dat({aw_h_id, aw_ok ? 2'b00 : 2'b11}),
    .pop(bus.bvalid & bus.bready), .head_dat({bus.bid, bus.bresp}),
    .empty(b_empty), .full(b_full), .count(b_count)
  );

  friscv_dmem_fifo #(.W(AXI_ID_W + 2 + AXI_DATA_W), .DEPTH(OSTD_NUM)) u_r_fifo (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .push(rd_pend),
    .push_dat({rd_id_q, rd_ok_q ? 2'b00 : 2'b11, rd_ok_q ? ram_q : {AXI_DATA_W{1'b0}}}),
    .pop(bus.rvalid & bus.rready), .head_dat({bus.rid, bus.rresp, bus.rdata}),
    .empty(r_empty), .full(r_full), .count(r_count)
  );

  assign bus.bvalid = run & ~b_empty;
  assign bus.rvalid = run & ~r_empty;

  // Read pipe stage: captures ID and range flag alongside the synchronous RAM read.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pend <= 1'b0;
      rd_id_q <= '0;
      rd_ok_q <= 1'b0;
    end else if (srst) begin
      rd_pend <= 1'b0;
      rd_id_q <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (issue) begin
        rd_id_q <= ar_h_id;
        rd_ok_q <= ar_ok;
      end
    end
  end

  // ---------------- RAM (not reset) ----------------
  // Read and write share one clocked block with non-blocking updates, so a same-cycle
  // read of the word being written sees the old contents.
  logic [AXI_DATA_W-1:0] ram [MEM_DEPTH];

  always_ff @(posedge aclk) begin
    if (issue) ram_q <= ram[ar_idx[MA-1:0]];
    if (commit && aw_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (w_h_strb[i]) ram[aw_idx[MA-1:0]][i*8 +: 8] <= w_h_dat[i*8 +: 8];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.awprot, bus.awcache, bus.arprot, bus.arcache,
                       aw_h_addr[OFF-1:0], ar_h_addr[OFF-1:0],
                       aw_count, w_count, ar_count, b_count, r_full};
endmodule
